// File: rtl/cache_way_alloc_pkg.sv
// Shared types for the cache replacement controller.
//   way_t         : way index of the 8-way set
//   NUM_WAYS      : ways per set
//   alloc_state_t : replacement sequencer states
package cache_types;

    typedef logic [2:0] way_t;

    localparam int unsigned NUM_WAYS = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        UPDATE    = 2'd3
    } alloc_state_t;

endpackage

// File: rtl/cache_way_alloc_if.sv
// Bus between the cache control side and the replacement controller.
// master : cache control / PLRU tree / metadata / memory side
// slave  : cache_way_alloc
//   req, hit, hit_way, valid_vec, dirty_vec, plru_way, mem_resp : master -> slave
//   plru_load, plru_mru, victim_way, mem_write, mem_read,
//   fill_load, done                                             : slave -> master
interface cache_way_alloc_if;
    import cache_types::*;

    logic                req;
    logic                hit;
    way_t                hit_way;
    logic [NUM_WAYS-1:0] valid_vec;
    logic [NUM_WAYS-1:0] dirty_vec;
    way_t                plru_way;
    logic                plru_load;
    way_t                plru_mru;
    way_t                victim_way;
    logic                mem_write;
    logic                mem_read;
    logic                mem_resp;
    logic                fill_load;
    logic                done;

    modport master (
        output req, hit, hit_way, valid_vec, dirty_vec, plru_way, mem_resp,
        input  plru_load, plru_mru, victim_way, mem_write, mem_read, fill_load, done
    );

    modport slave (
        input  req, hit, hit_way, valid_vec, dirty_vec, plru_way, mem_resp,
        output plru_load, plru_mru, victim_way, mem_write, mem_read, fill_load, done
    );

endinterface

// File: rtl/cache_way_alloc_way_prio_enc.sv
// Lowest-index invalid way finder.
//   valid_vec_i : valid bits of the indexed set
//   found_o     : at least one way is invalid
//   way_o       : lowest-index invalid way (0 when none found)
module way_prio_enc
    import cache_types::*;
(
    input  logic [NUM_WAYS-1:0] valid_vec_i,
    output logic                found_o,
    output way_t                way_o
);

    // Scan high to low so the lowest invalid index is the last one written.
    always_comb begin
        found_o = 1'b0;
        way_o   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_vec_i[i]) begin
                found_o = 1'b1;
                way_o   = way_t'(i);
            end
        end
    end

endmodule

// File: rtl/cache_way_alloc.sv
// Replacement controller for the 8-way cache: hit promotion and the miss path
// (victim select, dirty writeback, fill, MRU update).
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : cache_way_alloc_if.slave (request, set metadata, PLRU and memory handshake)
// Optional feature: ALLOC_INVALID_FIRST_EN -- prefer the lowest-index invalid way
// as victim over the PLRU choice.
module cache_way_alloc
    import cache_types::*;
#(
    parameter int unsigned s_way = 3  // only 3 (8 ways) is supported
) (
    input  logic                clk,
    input  logic                rst,
    cache_way_alloc_if.slave    bus
);

    alloc_state_t   state_q, state_d;
    way_t           victim_q, victim_d;
    logic [s_way-1:0] sel_way;
    logic           sel_wb;

`ifdef ALLOC_INVALID_FIRST_EN
    logic inv_found;
    way_t inv_way;

    way_prio_enc u_prio_enc (
        .valid_vec_i (bus.valid_vec),
        .found_o     (inv_found),
        .way_o       (inv_way)
    );

    // An invalid victim holds no data, so it never needs a writeback.
    assign sel_way = inv_found ? inv_way : bus.plru_way;
    assign sel_wb  = !inv_found && bus.valid_vec[bus.plru_way] && bus.dirty_vec[bus.plru_way];
`else
    assign sel_way = bus.plru_way;
    assign sel_wb  = bus.valid_vec[bus.plru_way] && bus.dirty_vec[bus.plru_way];
`endif

    logic plru_load, mem_write, mem_read, fill_load, done;
    way_t plru_mru;

    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        plru_load = 1'b0;
        plru_mru  = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        fill_load = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req && bus.hit) begin
                    done      = 1'b1;
                    plru_load = 1'b1;
                    plru_mru  = bus.hit_way;
                end else if (bus.req) begin
                    victim_d = sel_way;
                    state_d  = sel_wb ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                mem_write = 1'b1;
                if (bus.mem_resp) state_d = FILL;
            end
            FILL: begin
                mem_read = 1'b1;
                if (bus.mem_resp) begin
                    fill_load = 1'b1;
                    state_d   = UPDATE;
                end
            end
            UPDATE: begin
                plru_load = 1'b1;
                plru_mru  = victim_q;
                done      = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // The IDLE hit path is combinational from req/hit, so mask it while reset
    // is held to keep every output quiet during reset.
    assign bus.plru_load  = plru_load && !rst;
    assign bus.plru_mru   = rst ? '0 : plru_mru;
    assign bus.mem_write  = mem_write && !rst;
    assign bus.mem_read   = mem_read && !rst;
    assign bus.fill_load  = fill_load && !rst;
    assign bus.done       = done && !rst;
    assign bus.victim_way = victim_q;

endmodule

// File: tb/tb_cache_way_alloc.sv
module tb_cache_way_alloc;
    import cache_types::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    way_t last_victim;

    cache_way_alloc_if bus_if ();

    cache_way_alloc #(
        .s_way (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Victim chosen from the replacement rules, not from the RTL structure.
    function automatic way_t model_victim(input logic [7:0] vv, input way_t plru);
`ifdef ALLOC_INVALID_FIRST_EN
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!vv[i]) return way_t'(i);
        end
`endif
        return plru;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_done"}, {31'd0, bus_if.done}, 32'd0);
        check({tag, "_pload"}, {31'd0, bus_if.plru_load}, 32'd0);
        check({tag, "_mru"}, {29'd0, bus_if.plru_mru}, 32'd0);
        check({tag, "_mwr"}, {31'd0, bus_if.mem_write}, 32'd0);
        check({tag, "_mrd"}, {31'd0, bus_if.mem_read}, 32'd0);
        check({tag, "_fill"}, {31'd0, bus_if.fill_load}, 32'd0);
    endtask

    // Entered just after a rising edge with the controller idle.
    task automatic hit_access(input way_t w);
        bus_if.req      = 1'b1;
        bus_if.hit      = 1'b1;
        bus_if.hit_way  = w;
        bus_if.mem_resp = 1'($urandom);
        @(negedge clk);
        check("hit_done", {31'd0, bus_if.done}, 32'd1);
        check("hit_pload", {31'd0, bus_if.plru_load}, 32'd1);
        check("hit_mru", {29'd0, bus_if.plru_mru}, {29'd0, w});
        check("hit_mwr", {31'd0, bus_if.mem_write}, 32'd0);
        check("hit_mrd", {31'd0, bus_if.mem_read}, 32'd0);
        check("hit_fill", {31'd0, bus_if.fill_load}, 32'd0);
        check("hit_victim_stable", {29'd0, bus_if.victim_way}, {29'd0, last_victim});
        next_cycle();
        bus_if.req      = 1'b0;
        bus_if.hit      = 1'b0;
        bus_if.mem_resp = 1'b0;
        @(negedge clk);
        check_quiet("hit_after");
        next_cycle();
    endtask

    task automatic miss_access(input way_t plru, input logic [7:0] vv, input logic [7:0] dv,
                               input int wb_lat, input int fill_lat, input bit drop_req);
        way_t exp_v;
        bit   exp_wb;
        exp_v  = model_victim(vv, plru);
        exp_wb = vv[exp_v] && dv[exp_v];

        bus_if.req       = 1'b1;
        bus_if.hit       = 1'b0;
        bus_if.hit_way   = way_t'($urandom);
        bus_if.valid_vec = vv;
        bus_if.dirty_vec = dv;
        bus_if.plru_way  = plru;
        bus_if.mem_resp  = 1'b0;
        @(negedge clk);
        check_quiet("miss_req");
        next_cycle();
        last_victim = exp_v;

        // Metadata, hit and PLRU inputs are irrelevant once the victim is captured.
        bus_if.hit       = 1'($urandom);
        bus_if.hit_way   = way_t'($urandom);
        bus_if.plru_way  = way_t'($urandom);
        bus_if.valid_vec = 8'($urandom);
        bus_if.dirty_vec = 8'($urandom);
        if (drop_req) bus_if.req = 1'b0;

        if (exp_wb) begin
            for (int i = 0; i <= wb_lat; i++) begin
                bus_if.mem_resp = (i == wb_lat);
                @(negedge clk);
                check("wb_mwr", {31'd0, bus_if.mem_write}, 32'd1);
                check("wb_mrd", {31'd0, bus_if.mem_read}, 32'd0);
                check("wb_done", {31'd0, bus_if.done}, 32'd0);
                check("wb_pload", {31'd0, bus_if.plru_load}, 32'd0);
                check("wb_fill", {31'd0, bus_if.fill_load}, 32'd0);
                check("wb_victim", {29'd0, bus_if.victim_way}, {29'd0, exp_v});
                next_cycle();
            end
        end

        for (int i = 0; i <= fill_lat; i++) begin
            bus_if.mem_resp = (i == fill_lat);
            @(negedge clk);
            check("fill_mrd", {31'd0, bus_if.mem_read}, 32'd1);
            check("fill_mwr", {31'd0, bus_if.mem_write}, 32'd0);
            check("fill_load", {31'd0, bus_if.fill_load}, {31'd0, (i == fill_lat)});
            check("fill_done", {31'd0, bus_if.done}, 32'd0);
            check("fill_pload", {31'd0, bus_if.plru_load}, 32'd0);
            check("fill_victim", {29'd0, bus_if.victim_way}, {29'd0, exp_v});
            next_cycle();
        end

        // mem_resp in UPDATE must be ignored.
        bus_if.mem_resp = 1'($urandom);
        @(negedge clk);
        check("upd_done", {31'd0, bus_if.done}, 32'd1);
        check("upd_pload", {31'd0, bus_if.plru_load}, 32'd1);
        check("upd_mru", {29'd0, bus_if.plru_mru}, {29'd0, exp_v});
        check("upd_mrd", {31'd0, bus_if.mem_read}, 32'd0);
        check("upd_fill", {31'd0, bus_if.fill_load}, 32'd0);
        next_cycle();

        bus_if.req      = 1'b0;
        bus_if.hit      = 1'b0;
        bus_if.mem_resp = 1'b0;
        @(negedge clk);
        check_quiet("miss_after");
        check("miss_after_victim", {29'd0, bus_if.victim_way}, {29'd0, exp_v});
        next_cycle();
    endtask

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        last_victim      = '0;
        rst              = 1'b1;
        bus_if.req       = 1'b0;
        bus_if.hit       = 1'b0;
        bus_if.hit_way   = '0;
        bus_if.valid_vec = '0;
        bus_if.dirty_vec = '0;
        bus_if.plru_way  = '0;
        bus_if.mem_resp  = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset_victim", {29'd0, bus_if.victim_way}, 32'd0);
        rst = 1'b0;
        next_cycle();

        @(negedge clk);
        check_quiet("idle");
        next_cycle();

        hit_access(3'd5);
        miss_access(3'd2, 8'hFF, 8'h00, 0, 3, 1'b0);
        hit_access(3'd2);
        miss_access(3'd7, 8'hFF, 8'h80, 2, 1, 1'b0);
        miss_access(3'd0, 8'hF7, 8'h00, 0, 0, 1'b0);
        miss_access(3'd0, 8'hF7, 8'hFF, 1, 2, 1'b0);
        miss_access(3'd4, 8'hFF, 8'h10, 1, 1, 1'b1);

        // Reset in FILL: aborts at once, later mem_resp ignored.
        bus_if.req       = 1'b1;
        bus_if.hit       = 1'b0;
        bus_if.valid_vec = 8'hFF;
        bus_if.dirty_vec = 8'h00;
        bus_if.plru_way  = 3'd6;
        next_cycle();
        @(negedge clk);
        check("rst_pre_mrd", {31'd0, bus_if.mem_read}, 32'd1);
        #1;
        rst        = 1'b1;
        bus_if.req = 1'b0;
        #1;
        check_quiet("rst_async");
        check("rst_async_victim", {29'd0, bus_if.victim_way}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        bus_if.mem_resp = 1'b1;
        @(negedge clk);
        check_quiet("rst_late_resp");
        next_cycle();
        bus_if.mem_resp = 1'b0;
        last_victim     = '0;
        hit_access(3'd6);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                hit_access(way_t'($urandom));
            end else begin
                miss_access(way_t'($urandom), 8'($urandom | ($urandom_range(0, 1) ? 32'hFF : 32'h0)),
                            8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            1'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
